aes_inv_key_stream: RTL and testbench

//  Upstream key source for the AES-128 decrypt datapath. Accepts one 128-bit cipher key
//  and expands it iteratively into round keys rk[0..10], one per cycle.

---
 rtl/aes_inv_key_stream_pkg.sv | 56 +++++
 rtl/aes_key_expand_step.sv | 32 +++
 rtl/aes_inv_key_stream.sv | 95 +++++++++
 tb/tb_aes_inv_key_stream.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_inv_key_stream_pkg.sv
// AES-128 inverse key stream: shared constants and helpers.
// Holds the FSM encodings, the Rcon table and the forward S-box lookup.
package aes_inv_key_stream_pkg;

    localparam int AES_NR = 10;
    localparam logic [3:0] LAST_RK = 4'(AES_NR);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    // Forward S-box, byte 0x00 in the top eight bits.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sBox(input logic [7:0] b);
        logic [2047:0] sh;
        sh = SBOX_TBL << (8 * int'(b));
        return sh[2047:2040];
    endfunction

    function automatic logic [7:0] rconOf(input logic [3:0] i);
        logic [7:0] r;
        unique case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One AES-128 key-schedule step (combinational).
// Ports: rkIn = previous round key, rcon = round constant, rkNext = next round key.
module aes_key_expand_step
    import aes_inv_key_stream_pkg::*;
(
    input  logic [127:0] rkIn,
    input  logic [7:0]   rcon,
    output logic [127:0] rkNext
);

    logic [31:0] rotW;
    logic [31:0] subW;
    logic [31:0] t;
    logic [31:0] w0n;
    logic [31:0] w1n;
    logic [31:0] w2n;
    logic [31:0] w3n;

    assign rotW = {rkIn[23:0], rkIn[31:24]};

    assign subW = {sBox(rotW[31:24]), sBox(rotW[23:16]),
                   sBox(rotW[15:8]),  sBox(rotW[7:0])};

    assign t   = subW ^ {rcon, 24'h0};
    assign w0n = rkIn[127:96] ^ t;
    assign w1n = rkIn[95:64]  ^ w0n;
    assign w2n = rkIn[63:32]  ^ w1n;
    assign w3n = rkIn[31:0]   ^ w2n;

    assign rkNext = {w0n, w1n, w2n, w3n};

endmodule

// File: rtl/aes_inv_key_stream.sv
// Expands an AES-128 key into rk[0..10] and streams them rk[10]..rk[0].
// Ports: key_in/key_valid/key_ready in, rk_out/rk_idx/rk_valid/rk_ready out, busy.
module aes_inv_key_stream
    import aes_inv_key_stream_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy
);

    logic [1:0]   state;
    logic [3:0]   cnt;
    logic [127:0] rkMem [0:AES_NR];
    logic [127:0] prevKey;
    logic [127:0] stepOut;
    logic [7:0]   roundCon;
    logic         accept;
    logic         xfer;

    assign accept = (state == ST_IDLE) && key_valid;
    assign xfer   = rk_valid && rk_ready;

    assign prevKey  = rkMem[cnt - 4'd1];
    assign roundCon = rconOf(cnt);

    aes_key_expand_step uStep (
        .rkIn   (prevKey),
        .rcon   (roundCon),
        .rkNext (stepOut)
    );

    // Key store has no reset; it is only read after being written.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (accept) begin
                rkMem[0] <= key_in;
            end else if (state == ST_EXPAND) begin
                rkMem[cnt] <= stepOut;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            rk_out   <= '0;
            rk_idx   <= 4'd0;
            rk_valid <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (key_valid) begin
                        state <= ST_EXPAND;
                        cnt   <= 4'd1;
                    end
                end
                ST_EXPAND: begin
                    cnt <= cnt + 4'd1;
                    // Last key goes straight to the output register.
                    if (cnt == LAST_RK) begin
                        state    <= ST_STREAM;
                        rk_out   <= stepOut;
                        rk_idx   <= LAST_RK;
                        rk_valid <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (xfer) begin
                        if (rk_idx == 4'd0) begin
                            state    <= ST_IDLE;
                            rk_valid <= 1'b0;
                            cnt      <= 4'd0;
                        end else begin
                            rk_idx <= rk_idx - 4'd1;
                            rk_out <= rkMem[rk_idx - 4'd1];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign key_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_aes_inv_key_stream.sv
// Testbench for aes_inv_key_stream.
// Scoreboard of expected beats, pushed on key accept, popped per transfer.
module tb_aes_inv_key_stream;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready = 1'b1;
    logic         busy;

    aes_inv_key_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk_out    (rk_out),
        .rk_idx    (rk_idx),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] rk;
        bit           chk;
    } beat_t;

    typedef struct {
        logic [127:0] key;
        logic [127:0] rk10;
        bit           has10;
        bit           full;
    } vec_t;

    beat_t        sbq[$];
    vec_t         vecs[3];
    logic [127:0] fips[11];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acceptCyc = 0;
    int idx0Cyc = 0;
    bit readyRand = 1'b0;
    bit prevValid = 1'b0;
    bit prevStall = 1'b0;
    logic [3:0]   prevIdx = '0;
    logic [127:0] prevRk = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout/extra want event", name);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rk_ready = readyRand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        beat_t b;
        if (rst_n) begin
            if (rk_valid && !prevValid) begin
                check("firstIdx", 128'(rk_idx), 128'd10);
                check("latency", 128'(cyc - acceptCyc), 128'd11);
            end
            if (prevStall && rk_valid) begin
                check("stallIdx", 128'(rk_idx), 128'(prevIdx));
                check("stallRk", rk_out, prevRk);
            end
            if (busy && key_valid)
                check("readyBusy", 128'(key_ready), 128'd0);
            if (rk_valid && rk_ready) begin
                if (sbq.size() == 0) begin
                    fail("staleBeat");
                end else begin
                    b = sbq.pop_front();
                    check("beatIdx", 128'(rk_idx), 128'(b.idx));
                    if (b.chk)
                        check("beatRk", rk_out, b.rk);
                end
                if (rk_idx == 4'd0)
                    idx0Cyc = cyc;
            end
            prevStall = rk_valid && !rk_ready;
            prevIdx   = rk_idx;
            prevRk    = rk_out;
            prevValid = rk_valid;
        end else begin
            prevValid = 1'b0;
            prevStall = 1'b0;
        end
    end

    task automatic pushExp(input int v);
        beat_t b;
        for (int i = 10; i >= 0; i--) begin
            b.idx = 4'(i);
            b.rk  = '0;
            b.chk = 1'b0;
            if (vecs[v].full) begin
                b.rk  = fips[i];
                b.chk = 1'b1;
            end else if (i == 10 && vecs[v].has10) begin
                b.rk  = vecs[v].rk10;
                b.chk = 1'b1;
            end else if (i == 0) begin
                b.rk  = vecs[v].key;
                b.chk = 1'b1;
            end
            sbq.push_back(b);
        end
    endtask

    // Called at posedge+1; leaves key_valid high when tie is set.
    task automatic sendKey(input int v, input bit tie);
        key_in    = vecs[v].key;
        key_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (key_ready) begin
                pushExp(v);
                acceptCyc = cyc;
                @(posedge clk);
                #1;
                if (!tie)
                    key_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        key_valid = 1'b0;
        fail("acceptTimeout");
    endtask

    task automatic waitDrain();
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            if (sbq.size() == 0 && key_ready)
                return;
        end
        fail("drainTimeout");
    endtask

    initial begin
        bit found;
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        vecs[0] = '{fips[0], fips[10], 1'b1, 1'b1};
        vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f,
                    128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b1, 1'b0};
        vecs[2] = '{128'hdeadbeef0123456789abcdeffedcba98,
                    128'h0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("rstValid", 128'(rk_valid), 128'd0);
        check("rstKeyReady", 128'(key_ready), 128'd1);
        check("rstBusy", 128'(busy), 128'd0);
        check("rstRk", rk_out, 128'd0);
        check("rstIdx", 128'(rk_idx), 128'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // FIPS key, consumer always ready
        sendKey(0, 1'b0);
        waitDrain();

        // same key under random back-pressure
        readyRand = 1'b1;
        sendKey(0, 1'b0);
        waitDrain();
        sendKey(2, 1'b0);
        waitDrain();
        readyRand = 1'b0;

        // second reference key
        sendKey(1, 1'b0);
        waitDrain();

        // competing key held high while busy
        sendKey(0, 1'b0);
        key_in    = vecs[1].key;
        key_valid = 1'b1;
        sendKey(1, 1'b0);
        waitDrain();

        // reset in the middle of the stream
        sendKey(0, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(posedge clk);
            #1;
            if (rk_valid && rk_idx == 4'd5)
                found = 1'b1;
        end
        if (!found)
            fail("idx5Timeout");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sbq.delete();
        check("abortValid", 128'(rk_valid), 128'd0);
        check("abortKeyReady", 128'(key_ready), 128'd1);
        check("abortBusy", 128'(busy), 128'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("abortQuiet", 128'(rk_valid), 128'd0);
        end
        sendKey(1, 1'b0);
        waitDrain();

        // back-to-back keys with key_valid tied high
        sendKey(0, 1'b1);
        sendKey(1, 1'b1);
        key_valid = 1'b0;
        check("b2bGap", 128'(acceptCyc - idx0Cyc), 128'd1);
        waitDrain();

        repeat (3) @(posedge clk);
        #1;
        check("queueEmpty", 128'(sbq.size()), 128'd0);
        check("endIdle", 128'(busy), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
